iodelay_tap_cal: RTL and testbench

//  Consumer of idelay_ctrl_rdy from the 200 MHz IDELAYCTRL stage. Once the IDELAYCTRL
//  is calibrated, sweeps the variable IODELAY on the VGA ADC capture input through
//  all taps and measures a known alternating training pattern at each tap.

---
 rtl/iodelay_tap_cal_pkg.sv | 27 ++
 rtl/iodelay_tap_cal_sync_ff.sv | 27 ++
 rtl/iodelay_tap_cal.sv | 226 ++++++++++++++++++++++
 tb/tb_iodelay_tap_cal.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/iodelay_tap_cal_pkg.sv
// Shared definitions for the IODELAY tap calibration block.
//   TAP_BITS_DEF : default tap index width (64 taps)
//   TRAIN_TOGGLE : training pattern rule, consecutive samples must differ
//   cal_state_t  : calibration FSM states
//   train_ok()   : applies the training rule to one sample pair
package iodelay_tap_cal_pkg;

  localparam int unsigned TAP_BITS_DEF = 6;
  localparam logic        TRAIN_TOGGLE = 1'b1;

  typedef enum logic [3:0] {
    S_WAIT_RDY,
    S_RST_DLY,
    S_SETTLE,
    S_MEASURE,
    S_STEP,
    S_CENTRE,
    S_MOVE,
    S_DONE,
    S_ERR
  } cal_state_t;

  function automatic logic train_ok(input logic cur, input logic prev);
    return (cur ^ prev) == TRAIN_TOGGLE;
  endfunction

endpackage

// File: rtl/iodelay_tap_cal_sync_ff.sv
// Multi-flop synchroniser for a level signal crossing into clk.
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset, flops clear to 0
//   d     in  asynchronous level
//   q     out synchronised level, STAGES cycles of latency
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | STAGES'(d);
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/iodelay_tap_cal.sv
// Sweeps an IODELAY through every tap after IDELAYCTRL is ready, checks a
// toggling training pattern at each tap, then backs the delay off to the
// centre of the first contiguous good window.
//   clk_100MHz      in  capture clock
//   rst_n           in  asynchronous active-low reset
//   idelay_ctrl_rdy in  IDELAYCTRL RDY, asynchronous
//   start_cal       in  recalibrate pulse, honoured in DONE/ERR only
//   sample_bit      in  registered capture of the delayed input
//   dly_rst         out IODELAY RST (reload tap 0)
//   dly_ce          out IODELAY CE (one tap move per pulse)
//   dly_inc         out IODELAY INC (1 = up)
//   cal_tap         out tap currently applied
//   cal_done        out centred on the good window
//   cal_err         out no good tap found
module iodelay_tap_cal
  import iodelay_tap_cal_pkg::*;
#(
  parameter int unsigned TAP_BITS    = TAP_BITS_DEF,
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned WINDOW_CYC  = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  input  logic                idelay_ctrl_rdy,
  input  logic                start_cal,
  input  logic                sample_bit,
  output logic                dly_rst,
  output logic                dly_ce,
  output logic                dly_inc,
  output logic [TAP_BITS-1:0] cal_tap,
  output logic                cal_done,
  output logic                cal_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]    WINDOW_LAST = CNT_W'(WINDOW_CYC - 1);
  localparam logic [TAP_BITS-1:0] TAP_MAX     = '1;

  cal_state_t          r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [TAP_BITS-1:0] r_cal_tap, w_tap_n;
  logic [TAP_BITS-1:0] r_first, w_first_n;
  logic [TAP_BITS-1:0] r_last, w_last_n;
  logic [TAP_BITS-1:0] r_target, w_target_n;
  logic                r_found, w_found_n;
  logic                r_closed, w_closed_n;
  logic                r_win_ok, w_win_ok_n;
  logic                r_gap, w_gap_n;
  logic                r_prev;
  logic                r_dly_rst, r_dly_ce, r_dly_inc, r_cal_done, r_cal_err;
  logic                w_ce_n, w_inc_n;
  logic                w_rdy_s;
  logic                w_good;
  logic                w_closed_now;
  logic [TAP_BITS:0]   w_sum;
  logic [TAP_BITS-1:0] w_centre;

  sync_ff #(.STAGES(SYNC_STAGES)) u_rdy_sync (
    .clk   (clk_100MHz),
    .rst_n (rst_n),
    .d     (idelay_ctrl_rdy),
    .q     (w_rdy_s)
  );

  // Window verdict including the current cycle; r_prev holds the previous
  // cycle's sample, which is the last SETTLE sample on the first MEASURE cycle.
  assign w_good   = r_win_ok & train_ok(sample_bit, r_prev);
  assign w_sum    = {1'b0, r_first} + {1'b0, r_last};
  assign w_centre = TAP_BITS'(w_sum >> 1);

  always_comb begin
    w_state_n    = r_state;
    w_cnt_n      = r_cnt;
    w_tap_n      = r_cal_tap;
    w_first_n    = r_first;
    w_last_n     = r_last;
    w_target_n   = r_target;
    w_found_n    = r_found;
    w_closed_n   = r_closed;
    w_win_ok_n   = r_win_ok;
    w_gap_n      = r_gap;
    w_ce_n       = 1'b0;
    w_inc_n      = 1'b0;
    w_closed_now = r_closed;

    unique case (r_state)
      S_WAIT_RDY: begin
        if (w_rdy_s) w_state_n = S_RST_DLY;
      end
      S_RST_DLY: begin
        w_tap_n    = '0;
        w_first_n  = '0;
        w_last_n   = '0;
        w_found_n  = 1'b0;
        w_closed_n = 1'b0;
        w_cnt_n    = '0;
        w_state_n  = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_n    = '0;
          w_win_ok_n = 1'b1;
          w_state_n  = S_MEASURE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_MEASURE: begin
        w_win_ok_n = w_good;
        if (r_cnt == WINDOW_LAST) begin
          w_cnt_n = '0;
          if (w_good && !r_found) begin
            w_first_n = r_cal_tap;
            w_last_n  = r_cal_tap;
            w_found_n = 1'b1;
          end else if (w_good && !r_closed) begin
            w_last_n = r_cal_tap;
          end else if (!w_good && r_found) begin
            w_closed_n   = 1'b1;
            w_closed_now = 1'b1;
          end
          if (r_cal_tap == TAP_MAX || w_closed_now) begin
            w_state_n = S_CENTRE;
          end else begin
            w_state_n = S_STEP;
            w_ce_n    = 1'b1;
            w_inc_n   = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_STEP: begin
        if (r_cal_tap != TAP_MAX) w_tap_n = r_cal_tap + 1'b1;
        w_cnt_n   = '0;
        w_state_n = S_SETTLE;
      end
      S_CENTRE: begin
        w_cnt_n = '0;
        w_gap_n = 1'b0;
        if (!r_found) begin
          w_state_n = S_ERR;
        end else begin
          w_target_n = w_centre;
          w_state_n  = S_MOVE;
        end
      end
      S_MOVE: begin
        // r_gap marks the cycle the DEC pulse is on the pins; the next
        // decision waits one more cycle so CE never runs back to back.
        if (r_gap) begin
          w_gap_n = 1'b0;
        end else if (r_cal_tap > r_target) begin
          w_ce_n  = 1'b1;
          w_tap_n = r_cal_tap - 1'b1;
          w_gap_n = 1'b1;
        end else if (r_cnt == SETTLE_LAST) begin
          w_state_n = S_DONE;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (start_cal) w_state_n = S_RST_DLY;
      end
      default: w_state_n = S_WAIT_RDY;
    endcase

    if (!w_rdy_s) begin
      w_state_n = S_WAIT_RDY;
      w_ce_n    = 1'b0;
      w_inc_n   = 1'b0;
    end
  end

  // Control outputs are registered from the next state so each strobe is
  // high exactly for the cycle spent in RST_DLY / STEP / a MOVE gap.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAIT_RDY;
      r_cnt      <= '0;
      r_cal_tap  <= '0;
      r_first    <= '0;
      r_last     <= '0;
      r_target   <= '0;
      r_found    <= 1'b0;
      r_closed   <= 1'b0;
      r_win_ok   <= 1'b0;
      r_gap      <= 1'b0;
      r_prev     <= 1'b0;
      r_dly_rst  <= 1'b0;
      r_dly_ce   <= 1'b0;
      r_dly_inc  <= 1'b0;
      r_cal_done <= 1'b0;
      r_cal_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_cal_tap  <= w_tap_n;
      r_first    <= w_first_n;
      r_last     <= w_last_n;
      r_target   <= w_target_n;
      r_found    <= w_found_n;
      r_closed   <= w_closed_n;
      r_win_ok   <= w_win_ok_n;
      r_gap      <= w_gap_n;
      r_prev     <= sample_bit;
      r_dly_rst  <= (w_state_n == S_RST_DLY);
      r_dly_ce   <= w_ce_n;
      r_dly_inc  <= w_inc_n;
      r_cal_done <= (w_state_n == S_DONE);
      r_cal_err  <= (w_state_n == S_ERR);
    end
  end

  assign dly_rst  = r_dly_rst;
  assign dly_ce   = r_dly_ce;
  assign dly_inc  = r_dly_inc;
  assign cal_tap  = r_cal_tap;
  assign cal_done = r_cal_done;
  assign cal_err  = r_cal_err;

endmodule

// File: tb/tb_iodelay_tap_cal.sv
// Self-checking bench for iodelay_tap_cal with an IODELAY/training-data model.
module tb_iodelay_tap_cal;

  localparam int unsigned TAP_BITS = 6;
  localparam int unsigned SETTLE   = 4;
  localparam int unsigned WINDOW   = 16;
  localparam int unsigned SYNC     = 2;
  localparam int          NT       = 64;

  logic       clk_100MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       idelay_ctrl_rdy = 1'b1;
  logic       start_cal = 1'b0;
  logic       sample_bit = 1'b0;
  logic       dly_rst, dly_ce, dly_inc, cal_done, cal_err;
  logic [5:0] cal_tap;

  iodelay_tap_cal #(
    .TAP_BITS    (TAP_BITS),
    .SETTLE_CYC  (SETTLE),
    .WINDOW_CYC  (WINDOW),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_100MHz      (clk_100MHz),
    .rst_n           (rst_n),
    .idelay_ctrl_rdy (idelay_ctrl_rdy),
    .start_cal       (start_cal),
    .sample_bit      (sample_bit),
    .dly_rst         (dly_rst),
    .dly_ce          (dly_ce),
    .dly_inc         (dly_inc),
    .cal_tap         (cal_tap),
    .cal_done        (cal_done),
    .cal_err         (cal_err)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    int inc;
    int dec;
    int tap;
    bit err;
  } res_t;

  typedef struct {
    string       name;
    logic [63:0] mask;
    res_t        exp;
  } vec_t;

  vec_t vecs[6];

  logic [63:0] good_mask = '0;
  int tb_tap = 0;
  int n_inc = 0, n_dec = 0, n_rst = 0, n_viol = 0, cyc = 0;
  bit prev_ce = 1'b0;
  int n_checks = 0, n_pass = 0;

  // IODELAY + data source: good taps toggle every cycle, other taps give
  // random bits with a forced repeat every 8th cycle.
  always @(negedge clk_100MHz) begin
    cyc++;
    if (rst_n) begin
      if (dly_ce && dly_rst) n_viol++;
      if (dly_ce && prev_ce) n_viol++;
      prev_ce = dly_ce;
      if (dly_rst) begin
        n_rst++;
        tb_tap = 0;
      end else if (dly_ce) begin
        if (dly_inc) begin
          n_inc++;
          tb_tap = (tb_tap + 1) % NT;
        end else begin
          n_dec++;
          tb_tap = (tb_tap + NT - 1) % NT;
        end
      end
    end else begin
      prev_ce = 1'b0;
    end
    if (good_mask[tb_tap]) sample_bit = ~sample_bit;
    else if (cyc % 8 != 0) sample_bit = 1'($urandom_range(1, 0));
  end

  function automatic logic [63:0] range_mask(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int t = lo; t <= hi; t++) m[t] = 1'b1;
    return m;
  endfunction

  // Reference: first run of good taps, centre by floor average; the sweep
  // stops one tap past the run, or at the last tap.
  function automatic res_t ref_model(input logic [63:0] m);
    res_t r;
    int f = -1;
    int l;
    for (int t = NT - 1; t >= 0; t--) if (m[t]) f = t;
    if (f < 0) begin
      r.inc = NT - 1; r.dec = 0; r.tap = NT - 1; r.err = 1'b1;
      return r;
    end
    l = f;
    while (l < NT - 1 && m[l + 1]) l++;
    r.err = 1'b0;
    r.tap = (f + l) / 2;
    r.inc = (l == NT - 1) ? NT - 1 : l + 1;
    r.dec = r.inc - r.tap;
    return r;
  endfunction

  task automatic set_vec(input int idx, input string name, input logic [63:0] m,
                         input int inc, input int dec, input int tap, input bit err);
    vecs[idx].name    = name;
    vecs[idx].mask    = m;
    vecs[idx].exp.inc = inc;
    vecs[idx].exp.dec = dec;
    vecs[idx].exp.tap = tap;
    vecs[idx].exp.err = err;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr();
    n_inc = 0; n_dec = 0; n_rst = 0;
  endtask

  task automatic wait_end(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_100MHz);
      if (cal_done || cal_err) begin
        ok = 1'b1;
        break;
      end
    end
    chk({name, "_finish"}, int'(ok), 1);
  endtask

  task automatic check_result(input string name, input res_t e);
    chk({name, "_inc"},  n_inc, e.inc);
    chk({name, "_dec"},  n_dec, e.dec);
    chk({name, "_tap"},  int'(cal_tap), e.tap);
    chk({name, "_done"}, int'(cal_done), e.err ? 0 : 1);
    chk({name, "_err"},  int'(cal_err), e.err ? 1 : 0);
    chk({name, "_rst"},  n_rst, 1);
    chk({name, "_iodly"}, tb_tap, e.tap);
  endtask

  task automatic restart();
    @(negedge clk_100MHz);
    clr();
    start_cal = 1'b1;
    @(negedge clk_100MHz);
    start_cal = 1'b0;
  endtask

  initial begin
    bit ok;
    int lat;
    logic [63:0] rm;

    set_vec(0, "win20_40",  range_mask(20, 40),                      41, 11, 30, 1'b0);
    set_vec(1, "two_win",   range_mask(0, 5) | range_mask(50, 63),    6,  4,  2, 1'b0);
    set_vec(2, "no_toggle", 64'd0,                                   63,  0, 63, 1'b1);
    set_vec(3, "all_good",  range_mask(0, 63),                       63, 32, 31, 1'b0);
    set_vec(4, "top_only",  range_mask(63, 63),                      63,  0, 63, 1'b0);
    set_vec(5, "tap0_only", range_mask(0, 0),                         1,  1,  0, 1'b0);

    // Reset with RDY already high: everything idle.
    good_mask = vecs[0].mask;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_dly_rst",  int'(dly_rst), 0);
    chk("rst_dly_ce",   int'(dly_ce), 0);
    chk("rst_dly_inc",  int'(dly_inc), 0);
    chk("rst_cal_tap",  int'(cal_tap), 0);
    chk("rst_cal_done", int'(cal_done), 0);
    chk("rst_cal_err",  int'(cal_err), 0);

    clr();
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= int'(SYNC) + 2; i++) begin
      @(negedge clk_100MHz);
      if (dly_rst && lat == 0) lat = i;
    end
    chk("rst_pulse_seen", int'(lat != 0), 1);
    wait_end("first");
    check_result("first", vecs[0].exp);

    // Directed table through start_cal from DONE/ERR.
    for (int v = 0; v < 6; v++) begin
      good_mask = vecs[v].mask;
      restart();
      wait_end(vecs[v].name);
      check_result(vecs[v].name, vecs[v].exp);
    end

    // Random tap maps against the reference model.
    for (int k = 0; k < 6; k++) begin
      rm = {$urandom, $urandom};
      if (k % 2 == 0) rm = rm & {$urandom, $urandom};
      else            rm = rm | {$urandom, $urandom};
      good_mask = rm;
      restart();
      wait_end("rand");
      check_result("rand", ref_model(rm));
    end

    // RDY lost mid-MEASURE at tap 12, then regained.
    good_mask = range_mask(20, 40);
    restart();
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_100MHz);
      if (cal_tap == 6'd12) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_tap12", int'(ok), 1);
    repeat (SETTLE + 3) @(negedge clk_100MHz);
    idelay_ctrl_rdy = 1'b0;
    repeat (SYNC + 2) @(negedge clk_100MHz);
    clr();
    repeat (40) @(negedge clk_100MHz);
    chk("rdy_low_quiet", n_inc + n_dec + n_rst, 0);
    chk("rdy_low_done",  int'(cal_done), 0);
    clr();
    idelay_ctrl_rdy = 1'b1;
    wait_end("rdy_back");
    check_result("rdy_back", ref_model(range_mask(20, 40)));

    // start_cal clears DONE next cycle; a pulse mid-sweep is ignored.
    restart();
    chk("start_clears_done", int'(cal_done), 0);
    repeat (300) @(negedge clk_100MHz);
    start_cal = 1'b1;
    @(negedge clk_100MHz);
    start_cal = 1'b0;
    wait_end("mid_start");
    check_result("mid_start", ref_model(range_mask(20, 40)));

    // Asynchronous reset mid-sweep clears outputs without a clock edge.
    good_mask = range_mask(0, 63);
    restart();
    repeat (400) @(negedge clk_100MHz);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outs", int'({dly_rst, dly_ce, dly_inc, cal_done, cal_err, cal_tap}), 0);

    chk("ce_protocol", n_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
